seq_div16: RTL



---
 rtl/seq_div16.sv | 97 +++++++++
 1 files changed

// File: rtl/seq_div16.sv
// Iterative 16-bit unsigned restoring divider: one quotient bit per clock,
// quotient/remainder/div_by_zero published 16 cycles after an accepted start.
module seq_div16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        ready,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [16:0] r;
    logic [15:0] q;
    logic [15:0] d;
    logic        dz;

    logic [16:0] s;
    logic [17:0] t;
    logic        c;
    logic [16:0] r_next;
    logic [15:0] q_next;

    // Trial subtract S - {0,D} as S + {1,~D} + 1; bit 17 is the carry-out of bit 16.
    always_comb begin
        s      = {r[15:0], q[15]};
        t      = {1'b0, s} + {1'b0, 1'b1, ~d} + 18'd1;
        c      = t[17];
        r_next = c ? t[16:0] : s;
        q_next = {q[14:0], c};
    end

    // Handshake: a start is taken on any rising edge where start=1 and ready=1;
    // done is a single-cycle pulse with quotient/remainder/div_by_zero valid from then on.
    assign ready     = (state == IDLE) || (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            r           <= 17'd0;
            q           <= 16'd0;
            d           <= 16'd0;
            dz          <= 1'b0;
            done        <= 1'b0;
            quotient    <= 16'd0;
            remainder   <= 16'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        q     <= dividend;
                        d     <= divisor;
                        r     <= 17'd0;
                        cnt   <= 4'd0;
                        dz    <= (divisor == 16'd0);
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        quotient    <= q_next;
                        remainder   <= r_next[15:0];
                        div_by_zero <= dz;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
